serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit add/subtract built around a single
// 1-bit full adder (add1b). One result bit per clock, LSB first, with the
// carry fed back through a flip-flop. start/busy/done handshake.
//
// Optional feature macro: SERIAL_ADD_OVF_EN
//   defined   -> extra output ovf (two's-complement signed overflow),
//                updated together with co and held with r.
//   undefined -> no ovf port; everything else is identical.

// 1-bit full adder: the only arithmetic element in the datapath.
module add1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic r,
    output logic co
);
    assign r  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Reject widths outside the supported range at elaboration time.
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
        $error("serial_add_ctrl: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             r_bit;
    logic             co_bit;
    logic             accept;
    logic             last;

    // A new request is only taken when no operation is in flight; a start
    // during SHIFT is simply dropped.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == SHIFT) && (cnt == CNT_LAST);

    // The single adder: operand LSBs plus the registered carry.
    add1b u_add (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .r  (r_bit),
        .co (co_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: DONE lasts exactly one cycle unless a new start
    // arrives in it, in which case the next operation begins immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; busy and done are mutually exclusive by construction.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Datapath: operand capture on accept, one bit per SHIFT cycle.
    // Subtraction is A + ~B + 1: invert B at capture and seed the carry with 1.
    // r is never cleared on accept; its old bits are pushed out as new ones
    // enter at the MSB, so after WIDTH shifts it holds exactly the new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            r     <= '0;
            co    <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            r     <= {r_bit, r[WIDTH-1:1]};
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= co_bit;
            // Wrap to 0 on the final bit so cnt never exceeds WIDTH-1.
            cnt   <= last ? '0 : cnt + CW'(1);
            if (last) co <= co_bit;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow: on the last bit, carry holds the carry into the MSB
    // and co_bit is the carry out of it; they differ exactly on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ovf <= 1'b0;
        else if (last) ovf <= carry ^ co_bit;
    end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8). Stimulus pushes the
// hand-computed result when it issues a request; a monitor pops and compares
// each time done is seen, and also watches busy/done exclusion and r hold.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         co;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .co    (co)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         co;
        logic         ovf;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: compare on done, check invariants every cycle.
    logic [W-1:0] held_r;
    bit           holding = 1'b0;
    exp_t         e;

    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else begin
            if (busy && done) begin
                n_bad++;
                $display("FAIL busy_done_excl: busy=%0b done=%0b, required not both 1", busy, done);
            end
            if (busy) holding = 1'b0;
            if (holding && (r !== held_r)) begin
                n_bad++;
                $display("FAIL r_hold: r=%02h, required held %02h", r, held_r);
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: r=%02h co=%0b, required no done", r, co);
                end else begin
                    e = sbq.pop_front();
                    n_vec++;
                    if (r !== e.r || co !== e.co) begin
                        n_bad++;
                        $display("FAIL %s: r=%02h co=%0b, required r=%02h co=%0b", e.name, r, co, e.r, e.co);
                    end
`ifdef SERIAL_ADD_OVF_EN
                    n_vec++;
                    if (ovf !== e.ovf) begin
                        n_bad++;
                        $display("FAIL %s_ovf: ovf=%0b, required %0b", e.name, ovf, e.ovf);
                    end
`endif
                end
                held_r  = r;
                holding = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Drive one start cycle; called at edge+1. Operands are scrambled after
    // the edge to show they are captured, not sampled later.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                         input bit push, input logic [W-1:0] er, input logic ec,
                         input logic eo, input string nm);
        a = aa; b = bb; sub = s; start = 1'b1;
        if (push) sbq.push_back('{er, ec, eo, nm});
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    endtask

    // Bounded wait; returns at the negedge of the done cycle.
    task automatic wait_done(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) return;
        end
        n_vec++; n_bad++;
        $display("FAIL %s_timeout: done not seen, required within 20 cycles", nm);
    endtask

    // Called in the cycle after the accept edge: busy for W cycles, then done.
    task automatic lat_check(input string nm);
        for (int i = 0; i < W; i++) begin
            chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        chk({nm, "_done"}, {30'd0, done, busy}, 32'd2);
    endtask

    task automatic run_vec(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                           input logic [W-1:0] er, input logic ec, input logic eo,
                           input string nm);
        issue(aa, bb, s, 1'b1, er, ec, eo, nm);
        wait_done(nm);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {21'd0, busy, done, r, co}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: async reset in the middle of 0x12+0x34, then a clean 0x01+0x01
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "aborted");
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {21'd0, busy, done, r, co}, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst");

        // 2: latency of 0x0F+0x01
        issue(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, "add_0f_01");
        lat_check("lat1");
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, done}, 32'd0);

        // 3 and 5: wrap, borrow, signed-overflow corners
        run_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
        run_vec(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
        run_vec(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        run_vec(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "sub_zero");
        run_vec(8'h12, 8'h34, 1'b1, 8'hDE, 1'b0, 1'b0, "sub_12_34");
        run_vec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        run_vec(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "add_05_03");
        run_vec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80");

        // 4: start while busy is ignored; start in the DONE cycle is taken
        issue(8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, "add_01_02");
        repeat (3) @(posedge clk);
        #1;
        issue(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ignored");
        wait_done("add_01_02");
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        sbq.push_back('{8'h30, 1'b0, 1'b0, "b2b_10_20"});
        @(posedge clk); #1;
        start = 1'b0;
        lat_check("lat_b2b");
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
